// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational 1-bit shift/rotate step; out_bit is the bit that leaves the value.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  mode_t            mode,
    input  logic             fill,
    output logic [WIDTH-1:0] next,
    output logic             out_bit
);

    always_comb begin
        next    = value;
        out_bit = value[0];
        case (mode)
            MODE_LSL: begin
                next    = {value[WIDTH-2:0], fill};
                out_bit = value[WIDTH-1];
            end
            MODE_LSR: next = {fill, value[WIDTH-1:1]};
            MODE_ASR: next = {value[WIDTH-1], value[WIDTH-1:1]};
            MODE_ROR: next = {value[0], value[WIDTH-1:1]};
            default:  next = value;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: captures an operand and shifts it one bit per cycle for
// 'amount' cycles, then pulses done for one cycle.
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] S,
    output logic             bb,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    mode_t            mode_q;
    logic             fill_q;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (S),
        .mode    (mode_q),
        .fill    (fill_q),
        .next    (step_val),
        .out_bit (step_bit)
    );

    // A new request is only taken when not mid-shift; DONE accepts back-to-back.
    assign accept = start && (state != SHIFT);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (amount != '0) ? SHIFT : DONE;
            SHIFT:   if (count == AMT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = start ? ((amount != '0) ? SHIFT : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            S      <= '0;
            bb     <= 1'b0;
            count  <= '0;
            mode_q <= MODE_LSL;
            fill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                S      <= D;
                bb     <= 1'b0;
                mode_q <= mode_t'(mode);
                fill_q <= shift_in;
                count  <= amount;
            end else if (state == SHIFT) begin
                S     <= step_val;
                bb    <= step_bit;
                count <= count - AMT_W'(1);
            end
        end
    end

endmodule
